// File: rtl/md_pkg.sv
// Shared encodings for the mult/div issue controller: E-stage op codes,
// MulDivUnit op codes and the issue FSM state type.
package md_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [1:0] MD_UNIT_NONE = 2'd0;
  localparam logic [1:0] MD_UNIT_MUL  = 2'd1;
  localparam logic [1:0] MD_UNIT_DIV  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_t;

  function automatic logic is_md_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO storage: unit writeback or MT* write port, and the
// combinational MFHI/MFLO read mux.
module hilo_regfile
  import md_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic              mt_hi,
  input  logic              mt_lo,
  input  logic [DATA_W-1:0] mt_data,
  input  logic [3:0]        rd_op,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  // Writeback only happens in WAIT and MT* only in IDLE, so they never collide
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else if (wb_en) begin
      hi_r <= wb_hi;
      lo_r <= wb_lo;
    end else if (mt_hi) begin
      hi_r <= mt_data;
    end else if (mt_lo) begin
      lo_r <= mt_data;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // MF read mux
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    case (rd_op)
      MD_MFHI: rd_data = hi_r;
      MD_MFLO: rd_data = lo_r;
      default: rd_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// E-stage to MulDivUnit issue controller: decodes mult/div/HI/LO ops,
// runs the unit handshake and stalls the pipeline while an op is in flight.
module muldiv_issue_ctrl
  import md_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [3:0]        e_op,
  input  logic              e_flush,
  input  logic [DATA_W-1:0] e_rs,
  input  logic [DATA_W-1:0] e_rt,
  output logic              e_stall,
  output logic [DATA_W-1:0] e_rd,
  output logic [DATA_W-1:0] md_src0,
  output logic [DATA_W-1:0] md_src1,
  output logic [1:0]        md_op,
  output logic              md_sign,
  output logic              md_in_valid,
  input  logic              md_in_ready,
  input  logic              md_out_valid,
  output logic              md_out_ready,
  input  logic [DATA_W-1:0] md_res0,
  input  logic [DATA_W-1:0] md_res1
);

  md_state_t         state_r;
  md_state_t         state_nxt;
  logic              done_r;
  logic [DATA_W-1:0] src0_r;
  logic [DATA_W-1:0] src1_r;
  logic [1:0]        op_r;
  logic              sign_r;
  logic              e_live;
  logic              div_zero;
  logic              start;
  logic              wb_en;
  logic              mt_hi;
  logic              mt_lo;

  // Decode of the presented op. done_r marks the first IDLE cycle after a
  // writeback: the E-stage still shows the op that just completed, so it
  // must not be accepted a second time.
  always_comb begin
    e_live   = e_valid && !e_flush && (state_r == ST_IDLE);
    div_zero = is_md_div(e_op) && (e_rt == {DATA_W{1'b0}});
    start    = e_live && is_md_arith(e_op) && !div_zero && !done_r;
    mt_hi    = e_live && (e_op == MD_MTHI);
    mt_lo    = e_live && (e_op == MD_MTLO);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt    = state_r;
    wb_en        = 1'b0;
    md_in_valid  = 1'b0;
    md_out_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        md_in_valid = 1'b1;
        if (md_in_ready) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        md_out_ready = 1'b1;
        if (md_out_valid) begin
          wb_en     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    e_stall = (state_r != ST_IDLE) || start;
  end

  // State, completion flag and operand latch. op_r is held through WAIT
  // because the unit selects its result using the live op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      src0_r  <= {DATA_W{1'b0}};
      src1_r  <= {DATA_W{1'b0}};
      op_r    <= MD_UNIT_NONE;
      sign_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      done_r  <= wb_en;
      if (start) begin
        src0_r <= e_rs;
        src1_r <= e_rt;
        op_r   <= is_md_div(e_op) ? MD_UNIT_DIV : MD_UNIT_MUL;
        sign_r <= (e_op == MD_MULT) || (e_op == MD_DIV);
      end else if (wb_en) begin
        op_r   <= MD_UNIT_NONE;
      end else begin
        op_r   <= op_r;
      end
    end
  end

  assign md_src0 = src0_r;
  assign md_src1 = src1_r;
  assign md_op   = op_r;
  assign md_sign = sign_r;

  hilo_regfile #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clock   (clock),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_lo   (md_res0),
    .wb_hi   (md_res1),
    .mt_hi   (mt_hi),
    .mt_lo   (mt_lo),
    .mt_data (e_rs),
    .rd_op   (e_op),
    .rd_data (e_rd)
  );

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed self-checking bench for muldiv_issue_ctrl; the bench plays the
// MulDivUnit and supplies hand-computed results.
module tb_muldiv_issue_ctrl;
  import md_pkg::*;

  logic        clock;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic        e_flush;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        e_stall;
  logic [31:0] e_rd;
  logic [31:0] md_src0;
  logic [31:0] md_src1;
  logic [1:0]  md_op;
  logic        md_sign;
  logic        md_in_valid;
  logic        md_in_ready;
  logic        md_out_valid;
  logic        md_out_ready;
  logic [31:0] md_res0;
  logic [31:0] md_res1;

  int n_asserts = 0;
  int n_fails   = 0;

  muldiv_issue_ctrl #(.DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .e_valid      (e_valid),
    .e_op         (e_op),
    .e_flush      (e_flush),
    .e_rs         (e_rs),
    .e_rt         (e_rt),
    .e_stall      (e_stall),
    .e_rd         (e_rd),
    .md_src0      (md_src0),
    .md_src1      (md_src1),
    .md_op        (md_op),
    .md_sign      (md_sign),
    .md_in_valid  (md_in_valid),
    .md_in_ready  (md_in_ready),
    .md_out_valid (md_out_valid),
    .md_out_ready (md_out_ready),
    .md_res0      (md_res0),
    .md_res1      (md_res1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    e_valid = 1'b1;
    e_op    = MD_MFHI;
    #1;
    chk({tag, "_hi"}, e_rd, exp_hi);
    chk({tag, "_hi_nostall"}, {31'd0, e_stall}, 32'd0);
    e_op = MD_MFLO;
    #1;
    chk({tag, "_lo"}, e_rd, exp_lo);
  endtask

  // Full mul/div transaction: start, ISSUE (optionally held), WAIT, writeback, done cycle
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] res0, input logic [31:0] res1,
                        input logic exp_sign, input logic [1:0] exp_uop,
                        input int ready_delay, input int div_cycles);
    e_valid = 1'b1;
    e_op    = op;
    e_rs    = rs;
    e_rt    = rt;
    #1;
    chk({tag, "_start_stall"}, {31'd0, e_stall}, 32'd1);
    chk({tag, "_start_no_inv"}, {31'd0, md_in_valid}, 32'd0);
    cyc();
    for (int i = 0; i < ready_delay; i++) begin
      chk({tag, "_issue_hold"}, {31'd0, md_in_valid}, 32'd1);
      cyc();
    end
    chk({tag, "_in_valid"}, {31'd0, md_in_valid}, 32'd1);
    chk({tag, "_src0"}, md_src0, rs);
    chk({tag, "_src1"}, md_src1, rt);
    chk({tag, "_op"}, {30'd0, md_op}, {30'd0, exp_uop});
    chk({tag, "_sign"}, {31'd0, md_sign}, {31'd0, exp_sign});
    chk({tag, "_issue_stall"}, {31'd0, e_stall}, 32'd1);
    md_in_ready = 1'b1;
    cyc();
    md_in_ready = 1'b0;
    chk({tag, "_out_ready"}, {31'd0, md_out_ready}, 32'd1);
    chk({tag, "_wait_no_inv"}, {31'd0, md_in_valid}, 32'd0);
    for (int i = 0; i < div_cycles; i++) begin
      chk({tag, "_wait_op"}, {30'd0, md_op}, {30'd0, exp_uop});
      chk({tag, "_wait_stall"}, {31'd0, e_stall}, 32'd1);
      cyc();
    end
    md_out_valid = 1'b1;
    md_res0      = res0;
    md_res1      = res1;
    #1;
    chk({tag, "_wb_op"}, {30'd0, md_op}, {30'd0, exp_uop});
    chk({tag, "_wb_stall"}, {31'd0, e_stall}, 32'd1);
    cyc();
    md_out_valid = 1'b0;
    md_res0      = 32'hDEAD_BEEF;
    md_res1      = 32'hBAAD_F00D;
    #1;
    chk({tag, "_done_stall"}, {31'd0, e_stall}, 32'd0);
    chk({tag, "_done_op"}, {30'd0, md_op}, 32'd0);
    chk({tag, "_done_out_ready"}, {31'd0, md_out_ready}, 32'd0);
    chk({tag, "_done_no_inv"}, {31'd0, md_in_valid}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    e_valid      = 1'b0;
    e_op         = MD_NONE;
    e_flush      = 1'b0;
    e_rs         = 32'd0;
    e_rt         = 32'd0;
    md_in_ready  = 1'b0;
    md_out_valid = 1'b0;
    md_res0      = 32'd0;
    md_res1      = 32'd0;
    #2;
    chk("rst_stall", {31'd0, e_stall}, 32'd0);
    chk("rst_rd", e_rd, 32'd0);
    chk("rst_in_valid", {31'd0, md_in_valid}, 32'd0);
    chk("rst_out_ready", {31'd0, md_out_ready}, 32'd0);
    chk("rst_op", {30'd0, md_op}, 32'd0);
    chk("rst_sign", {31'd0, md_sign}, 32'd0);
    chk("rst_src0", md_src0, 32'd0);
    cyc();
    reset = 1'b0;
    read_hilo("rst_hilo", 32'd0, 32'd0);

    // 1. signed multiply -3 * 7
    run_md("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b1, MD_UNIT_MUL, 0, 0);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    cyc();

    // 2. unsigned multiply
    run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b0, MD_UNIT_MUL, 0, 0);
    read_hilo("multu", 32'd1, 32'hFFFF_FFFE);
    cyc();

    // 3. signed divide -7 / 2, issue held one cycle, several divider cycles
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, MD_UNIT_DIV, 1, 4);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    cyc();

    // 4. preload via MT*, then divide by zero must not issue or change HI/LO
    e_op = MD_MTHI;
    e_rs = 32'd5;
    #1;
    chk("mthi_nostall", {31'd0, e_stall}, 32'd0);
    cyc();
    e_op = MD_MTLO;
    e_rs = 32'd6;
    cyc();
    read_hilo("mt", 32'd5, 32'd6);
    cyc();
    e_op = MD_MTHI;
    e_rs = 32'd99;
    e_flush = 1'b1;
    cyc();
    e_flush = 1'b0;
    read_hilo("mt_flushed", 32'd5, 32'd6);
    cyc();
    e_op = MD_DIVU;
    e_rs = 32'd100;
    e_rt = 32'd0;
    #1;
    chk("divz_stall", {31'd0, e_stall}, 32'd0);
    cyc();
    chk("divz_in_valid", {31'd0, md_in_valid}, 32'd0);
    chk("divz_op", {30'd0, md_op}, 32'd0);
    read_hilo("divz", 32'd5, 32'd6);
    cyc();

    // flushed MULT and an unused encoding are both dropped
    e_op    = MD_MULT;
    e_rs    = 32'd4;
    e_rt    = 32'd4;
    e_flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, e_stall}, 32'd0);
    cyc();
    chk("flush_in_valid", {31'd0, md_in_valid}, 32'd0);
    e_flush = 1'b0;
    e_op    = 4'hF;
    #1;
    chk("unused_stall", {31'd0, e_stall}, 32'd0);
    chk("unused_rd", e_rd, 32'd0);
    cyc();
    chk("unused_in_valid", {31'd0, md_in_valid}, 32'd0);

    // 5. DIVU 100/7 followed by MFLO / MFHI
    run_md("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, MD_UNIT_DIV, 0, 3);
    read_hilo("divu", 32'd2, 32'd14);
    cyc();

    // 6. reset in the middle of WAIT of a DIV
    e_valid = 1'b1;
    e_op    = MD_DIV;
    e_rs    = 32'hFFFF_FFF9;
    e_rt    = 32'd2;
    md_in_ready = 1'b1;
    cyc();
    cyc();
    md_in_ready = 1'b0;
    chk("rstw_in_wait", {31'd0, md_out_ready}, 32'd1);
    chk("rstw_op_before", {30'd0, md_op}, {30'd0, MD_UNIT_DIV});
    #2;
    e_op  = MD_MFHI;
    reset = 1'b1;
    #1;
    chk("rstw_out_ready", {31'd0, md_out_ready}, 32'd0);
    chk("rstw_op", {30'd0, md_op}, 32'd0);
    chk("rstw_src0", md_src0, 32'd0);
    chk("rstw_hi", e_rd, 32'd0);
    chk("rstw_stall", {31'd0, e_stall}, 32'd0);
    cyc();
    reset = 1'b0;
    read_hilo("rstw_hilo", 32'd0, 32'd0);
    run_md("post_rst", MD_MULT, 32'd2, 32'd3, 32'd6, 32'd0, 1'b1, MD_UNIT_MUL, 0, 0);
    read_hilo("post_rst", 32'd0, 32'd6);
    cyc();
    e_valid = 1'b0;
    e_op    = MD_NONE;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
